// File: rtl/fetch_ctrl.sv
// PC / instruction-register controller for the five-phase multi-cycle CPU.
// Loads IR at fetch, advances or redirects PC at writeback, retires, and latches HALT.
module fetch_ctrl #(
    parameter int unsigned           AW       = 16,
    parameter int unsigned           IW       = 32,
    parameter int unsigned           OPW      = 6,
    parameter logic [OPW-1:0]        HALT_OP  = 6'h3f,
    parameter logic [AW-1:0]         RESET_PC = '0
) (
    input  logic          clk,
    input  logic          n_rst,
    input  logic [4:0]    phase,
    output logic [AW-1:0] imem_addr,
    input  logic [IW-1:0] imem_rdata,
    input  logic          br_taken,
    input  logic [AW-1:0] br_target,
    output logic [AW-1:0] pc,
    output logic [IW-1:0] ir,
    output logic          hlt,
    output logic [31:0]   retire_cnt,
    output logic          phase_err
);

    logic [AW-1:0] r_pc;
    logic [IW-1:0] r_ir;
    logic          r_hlt;
    logic [31:0]   r_retire_cnt;
    logic          r_phase_err;

    logic          w_legal;
    logic          w_fetch;
    logic          w_wb;
    logic          w_halt_op;

    // Legal means zero or one bit set; multi-hot phases freeze everything but the error flag.
    always_comb begin
        w_legal   = ((phase & (phase - 5'd1)) == 5'd0);
        w_fetch   = (phase == 5'b00001);
        w_wb      = (phase == 5'b10000);
        w_halt_op = (imem_rdata[IW-1:IW-OPW] == HALT_OP);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_phase_err <= 1'b0;
        end else if (!w_legal) begin
            r_phase_err <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_ir  <= '0;
            r_hlt <= 1'b0;
        end else if (w_fetch) begin
            r_ir <= imem_rdata;
            if (w_halt_op) begin
                r_hlt <= 1'b1;
            end
        end
    end

    // Once halted, writeback neither moves the PC nor retires.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_pc         <= RESET_PC;
            r_retire_cnt <= '0;
        end else if (w_wb && !r_hlt) begin
            r_pc         <= br_taken ? br_target : (r_pc + 1'b1);
            r_retire_cnt <= r_retire_cnt + 32'd1;
        end
    end

    assign imem_addr  = r_pc;
    assign pc         = r_pc;
    assign ir         = r_ir;
    assign hlt        = r_hlt;
    assign retire_cnt = r_retire_cnt;
    assign phase_err  = r_phase_err;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed test-plan scenarios followed by
// randomized phase/instruction streams compared against a rule-level reference model.
module tb_fetch_ctrl;

    logic        clk;
    logic        n_rst;
    logic [4:0]  phase;
    logic [15:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        br_taken;
    logic [15:0] br_target;
    logic [15:0] pc;
    logic [31:0] ir;
    logic        hlt;
    logic [31:0] retire_cnt;
    logic        phase_err;

    fetch_ctrl #(
        .AW      (16),
        .IW      (32),
        .OPW     (6),
        .HALT_OP (6'h3f),
        .RESET_PC(16'h0000)
    ) dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .phase     (phase),
        .imem_addr (imem_addr),
        .imem_rdata(imem_rdata),
        .br_taken  (br_taken),
        .br_target (br_target),
        .pc        (pc),
        .ir        (ir),
        .hlt       (hlt),
        .retire_cnt(retire_cnt),
        .phase_err (phase_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Reference state, kept as plain integers.
    longint      m_pc;
    logic [31:0] m_ir;
    bit          m_hlt;
    longint      m_cnt;
    bit          m_perr;

    localparam logic [4:0] PH_F = 5'b00001;
    localparam logic [4:0] PH_R = 5'b00010;
    localparam logic [4:0] PH_X = 5'b00100;
    localparam logic [4:0] PH_M = 5'b01000;
    localparam logic [4:0] PH_W = 5'b10000;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc   = 0;
        m_ir   = '0;
        m_hlt  = 0;
        m_cnt  = 0;
        m_perr = 0;
    endtask

    task automatic model_step(input logic [4:0] ph, input logic [31:0] rd,
                              input bit bt, input logic [15:0] tgt);
        if ($countones(ph) > 1) begin
            m_perr = 1;
        end else if (ph == PH_F) begin
            m_ir = rd;
            if (rd[31:26] == 6'h3f) m_hlt = 1;
        end else if (ph == PH_W && !m_hlt) begin
            m_pc  = bt ? longint'(tgt) : (m_pc + 1) % 65536;
            m_cnt = (m_cnt + 1) % (longint'(1) << 32);
        end
    endtask

    task automatic check_all(input string where);
        chk({where, ".pc"},        64'(pc),         64'(m_pc));
        chk({where, ".imem_addr"}, 64'(imem_addr),  64'(m_pc));
        chk({where, ".ir"},        64'(ir),         64'(m_ir));
        chk({where, ".hlt"},       64'(hlt),        64'(m_hlt));
        chk({where, ".retire"},    64'(retire_cnt), 64'(m_cnt));
        chk({where, ".perr"},      64'(phase_err),  64'(m_perr));
    endtask

    // Called at posedge+1; returns at the next posedge+1 with outputs checked.
    task automatic step(input logic [4:0] ph, input logic [31:0] rd,
                        input bit bt, input logic [15:0] tgt);
        phase      = ph;
        imem_rdata = rd;
        br_taken   = bt;
        br_target  = tgt;
        @(posedge clk);
        model_step(ph, rd, bt, tgt);
        #1;
        check_all("step");
    endtask

    task automatic do_reset();
        n_rst = 1'b0;
        #2;
        model_reset();
        check_all("rst");
        phase    = '0;
        br_taken = 1'b0;
        @(negedge clk);
        n_rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_word(input bit halt);
        logic [31:0] w;
        w = $urandom;
        if (halt) w[31:26] = 6'h3f;
        else if (w[31:26] == 6'h3f) w[31] = 1'b0;
        return w;
    endfunction

    // One instruction through f..w; a HALT stops after r as the phase generator would.
    task automatic instr(input logic [31:0] word, input bit bt, input logic [15:0] tgt,
                         input bit noise);
        step(PH_F, word, noise && $urandom_range(0, 1) == 1, 16'($urandom));
        step(PH_R, rand_word(0), noise && $urandom_range(0, 1) == 1, 16'($urandom));
        if (m_hlt) return;
        step(PH_X, rand_word(0), noise, 16'($urandom));
        step(PH_M, rand_word(0), noise && $urandom_range(0, 1) == 1, 16'($urandom));
        step(PH_W, rand_word(0), bt, tgt);
    endtask

    logic [31:0] w3;
    logic [4:0]  bad;

    initial begin
        n_rst      = 1'b1;
        phase      = '0;
        imem_rdata = '0;
        br_taken   = 1'b0;
        br_target  = '0;
        model_reset();
        #3;
        do_reset();
        check_all("reset");

        // Three sequential instructions.
        instr(rand_word(0), 0, 16'h0, 0);
        chk("seq1.pc", 64'(pc), 64'd1);
        instr(rand_word(0), 0, 16'h0, 0);
        chk("seq2.pc", 64'(pc), 64'd2);
        w3 = rand_word(0);
        instr(w3, 0, 16'h0, 0);
        chk("seq3.pc", 64'(pc), 64'd3);
        chk("seq3.retire", 64'(retire_cnt), 64'd3);
        chk("seq3.ir", 64'(ir), 64'(w3));

        // Branch from pc=5, then branch pulse in x only is ignored.
        instr(rand_word(0), 0, 16'h0, 0);
        instr(rand_word(0), 0, 16'h0, 0);
        chk("pre_br.pc", 64'(pc), 64'd5);
        instr(rand_word(0), 1, 16'h0100, 0);
        chk("br.pc", 64'(pc), 64'h100);
        instr(rand_word(0), 1, 16'h0005, 0);
        step(PH_F, rand_word(0), 0, 16'h0);
        step(PH_R, rand_word(0), 0, 16'h0);
        step(PH_X, rand_word(0), 1, 16'h0100);
        step(PH_M, rand_word(0), 0, 16'h0);
        step(PH_W, rand_word(0), 0, 16'h0);
        chk("br_x_ignored.pc", 64'(pc), 64'd6);

        // PC wrap.
        instr(rand_word(0), 1, 16'hffff, 0);
        instr(rand_word(0), 0, 16'h0, 0);
        chk("wrap.pc", 64'(pc), 64'd0);
        chk("wrap.retire", 64'(retire_cnt), 64'd10);

        // Illegal phase for one cycle, then normal operation.
        step(5'b00101, rand_word(0), 1, 16'h1234);
        chk("illegal.perr", 64'(phase_err), 64'd1);
        chk("illegal.pc", 64'(pc), 64'd0);
        instr(rand_word(0), 0, 16'h0, 0);
        chk("after_illegal.pc", 64'(pc), 64'd1);
        chk("after_illegal.perr", 64'(phase_err), 64'd1);

        // Reset during phase m of an instruction.
        step(PH_F, rand_word(0), 0, 16'h0);
        step(PH_R, rand_word(0), 0, 16'h0);
        step(PH_X, rand_word(0), 0, 16'h0);
        phase = PH_M;
        do_reset();
        chk("rst_m.pc", 64'(pc), 64'd0);
        chk("rst_m.retire", 64'(retire_cnt), 64'd0);
        chk("rst_m.ir", 64'(ir), 64'd0);
        chk("rst_m.perr", 64'(phase_err), 64'd0);

        // HALT at pc=7.
        instr(rand_word(0), 1, 16'h0007, 0);
        step(PH_F, rand_word(1), 0, 16'h0);
        chk("halt.hlt", 64'(hlt), 64'd1);
        step(PH_R, rand_word(0), 0, 16'h0);
        for (int i = 0; i < 4; i++) step(5'b00000, rand_word(1), 1, 16'h0abc);
        step(PH_W, rand_word(0), 1, 16'h0abc);
        chk("halt.pc", 64'(pc), 64'd7);
        chk("halt.retire", 64'(retire_cnt), 64'd1);
        chk("halt.sticky", 64'(hlt), 64'd1);
        do_reset();
        chk("halt_clr.hlt", 64'(hlt), 64'd0);

        // Randomized instruction streams.
        for (int n = 0; n < 300; n++) begin
            int unsigned idle;
            idle = $urandom_range(0, 2);
            for (int i = 0; i < int'(idle); i++) step(5'b00000, $urandom, $urandom_range(0, 1) == 1, 16'($urandom));
            if ($urandom_range(0, 19) == 0) begin
                do bad = 5'($urandom); while ($countones(bad) < 2);
                step(bad, $urandom, 1, 16'($urandom));
            end
            if (m_hlt) begin
                step(PH_W, $urandom, $urandom_range(0, 1) == 1, 16'($urandom));
                do_reset();
                check_all("rand_rst");
            end else if ($urandom_range(0, 39) == 0) begin
                step(PH_F, rand_word(0), 0, 16'h0);
                phase = PH_R;
                do_reset();
            end else begin
                instr(rand_word($urandom_range(0, 14) == 0),
                      $urandom_range(0, 3) == 0,
                      ($urandom_range(0, 4) == 0) ? 16'hffff : 16'($urandom), 1);
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
